// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding, the NOP fill word and the instruction
// field layout used when assembling program images.
package imem_boot_loader_pkg;

  // Loader state. ST_FILL is only reachable when ZERO_FILL_EN is defined.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // Word written to unused addresses by the fill pass. It is cast down to the
  // instruction width where it is used.
  localparam logic [63:0] NOP_WORD = '0;

  // Instruction field layout: {opcode[6:0], DR[2:0], SA[2:0], SB[2:0]}.
  localparam int OPC_W = 7;
  localparam int REG_W = 3;

  localparam logic [OPC_W-1:0] OPC_MOVA = 7'h00;
  localparam logic [OPC_W-1:0] OPC_ADD  = 7'h02;
  localparam logic [OPC_W-1:0] OPC_SUB  = 7'h05;
  localparam logic [OPC_W-1:0] OPC_AND  = 7'h08;
  localparam logic [OPC_W-1:0] OPC_LD   = 7'h10;
  localparam logic [OPC_W-1:0] OPC_ST   = 7'h20;

  // Assemble one 16-bit instruction word from its fields.
  function automatic logic [15:0] mk_instr(input logic [OPC_W-1:0] opc,
                                           input logic [REG_W-1:0] dr,
                                           input logic [REG_W-1:0] sa,
                                           input logic [REG_W-1:0] sb);
    return {opc, dr, sa, sb};
  endfunction

endpackage

// File: rtl/boot_hold_counter.sv
// Down-counter that times how long the processor stays in reset after the
// final memory write. Loading presets HOLD_CYC-1 so that, counting the cycle
// in which the counter is loaded, exactly HOLD_CYC cycles elapse before
// o_zero is seen with the counter having run down.
module boot_hold_counter #(
  parameter int HOLD_CYC = 2,
  localparam int CW = $clog2(HOLD_CYC + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  logic [CW-1:0] r_count;

  // Preset on load, otherwise count down and saturate at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(HOLD_CYC - 1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory over a valid/ready channel
// while holding the processor in reset, then releases it after a short delay.
// A reload pulse while running restarts loading without a global reset.
// Optional macro ZERO_FILL_EN: after a short image, write NOP to every
// remaining address before releasing the processor.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int WORD_W   = 16,
  parameter int DEPTH    = 8,
  parameter int HOLD_CYC = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic [AW:0]       words_loaded
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e            r_state;
  logic              r_ready;
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [AW-1:0]     r_ptr;
  logic [AW:0]       r_words;

  state_e            w_state_next;
  logic              w_ready_next;
  logic              w_we_next;
  logic [AW-1:0]     w_addr_next;
  logic [WORD_W-1:0] w_wdata_next;
  logic [AW-1:0]     w_ptr_next;
  logic [AW:0]       w_words_next;
  logic              w_accept;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

  assign w_accept = ld_valid && r_ready && (r_state == ST_LOAD);

  boot_hold_counter #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero)
  );

  // Next-state and next-output decode for the load/fill/hold/run sequence.
  always_comb begin
    w_state_next = r_state;
    w_we_next    = 1'b0;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_ptr_next   = r_ptr;
    w_words_next = r_words;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          w_we_next    = 1'b1;
          w_addr_next  = r_ptr;
          w_wdata_next = ld_data;
          w_ptr_next   = r_ptr + AW'(1);
          w_words_next = r_words + (AW+1)'(1);
          // A write to the top address ends the image regardless of ld_last,
          // so the pointer can never wrap onto already loaded words.
          if (r_ptr == LAST_ADDR) begin
            w_state_next = ST_HOLD;
            w_cnt_load   = 1'b1;
          end else if (ld_last) begin
`ifdef ZERO_FILL_EN
            w_state_next = ST_FILL;
`else
            w_state_next = ST_HOLD;
            w_cnt_load   = 1'b1;
`endif
          end
        end
      end
`ifdef ZERO_FILL_EN
      ST_FILL: begin
        // One NOP per cycle from the first unused address up to the top.
        w_we_next    = 1'b1;
        w_addr_next  = r_ptr;
        w_wdata_next = WORD_W'(NOP_WORD);
        w_ptr_next   = r_ptr + AW'(1);
        if (r_ptr == LAST_ADDR) begin
          w_state_next = ST_HOLD;
          w_cnt_load   = 1'b1;
        end
      end
`endif
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_state_next = ST_RUN;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (reload) begin
          w_state_next = ST_LOAD;
          w_ptr_next   = '0;
          w_addr_next  = '0;
          w_words_next = '0;
        end
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
    // Ready is raised only once the loader has already spent a cycle in LOAD,
    // which gives the one-cycle gap after reset release and after reload.
    w_ready_next = (r_state == ST_LOAD) && (w_state_next == ST_LOAD);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_LOAD;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ptr   <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state_next;
      r_ready <= w_ready_next;
      r_we    <= w_we_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_ptr   <= w_ptr_next;
      r_words <= w_words_next;
    end
  end

  assign ld_ready     = r_ready;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign words_loaded = r_words;
  assign cpu_reset    = (r_state != ST_RUN);
  assign done         = (r_state == ST_RUN);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard: each word sent
// pushes its expected {address, data}; a monitor pops and compares on every
// mem_we cycle. Build with +define+ZERO_FILL_EN to exercise the fill pass.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int WORD_W   = 16;
  localparam int DEPTH    = 8;
  localparam int HOLD_CYC = 2;
  localparam int AW       = 3;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              ld_valid = 1'b0;
  logic [WORD_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              reload = 1'b0;
  logic              ld_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic [AW:0]       words_loaded;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail = 0;
  int  next_addr = 0;
  int  n_fill;
  logic [WORD_W-1:0] img1 [6];

  imem_boot_loader #(
    .WORD_W   (WORD_W),
    .DEPTH    (DEPTH),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .reload       (reload),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge CLK) begin
    if (!RESET && mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
      end
      $display("[TB] write addr=%0d data=%04h", mem_addr, mem_wdata);
    end
  end

  // Present one word and return one cycle after it has been accepted.
  task automatic send(input logic [WORD_W-1:0] d, input logic last);
    int bound;
    bound = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    sb_q.push_back('{addr: AW'(next_addr), data: d});
    next_addr++;
    while (ld_ready !== 1'b1 && bound < 20) begin
      @(negedge CLK); #1;
      bound++;
    end
    check("accept_ready", 32'(ld_ready), 32'd1);
    @(negedge CLK); #1;
  endtask

  // Queue the NOP writes expected after an ld_last termination.
  function automatic int push_fill();
    int n;
    n = 0;
`ifdef ZERO_FILL_EN
    while (next_addr < DEPTH) begin
      sb_q.push_back('{addr: AW'(next_addr), data: WORD_W'(0)});
      next_addr++;
      n++;
    end
`endif
    return n;
  endfunction

  // Called in the cycle the last image word is visible: cpu_reset must stay
  // high for the fill writes plus HOLD_CYC cycles, then drop with done set.
  task automatic expect_release(input int nfill);
    for (int i = 0; i < nfill + HOLD_CYC; i++) begin
      check("cpu_reset_hold", 32'(cpu_reset), 32'd1);
      check("done_low", 32'(done), 32'd0);
      @(negedge CLK); #1;
      reload = 1'b0;
    end
    check("cpu_reset_run", 32'(cpu_reset), 32'd0);
    check("done_run", 32'(done), 32'd1);
    check("ready_run", 32'(ld_ready), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reload();
    check("pre_reload_done", 32'(done), 32'd1);
    reload = 1'b1;
    @(negedge CLK); #1;
    reload = 1'b0;
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd0);
    check("reload_ready_gap", 32'(ld_ready), 32'd0);
    @(negedge CLK); #1;
    check("reload_ready", 32'(ld_ready), 32'd1);
    next_addr = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_ready"}, 32'(ld_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    img1[0] = 16'h9819; img1[1] = 16'h9826; img1[2] = 16'h401C;
    img1[3] = 16'h20D8; img1[4] = 16'h8491; img1[5] = 16'h04D3;

    // Reset state and the one-cycle ready gap after release.
    #3;
    check_reset_values("reset");
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("ready_first_cycle", 32'(ld_ready), 32'd0);
    @(negedge CLK); #1;
    check("ready_after_reset", 32'(ld_ready), 32'd1);

    // Six-word image, valid held high; a reload pulse during HOLD is ignored.
    for (int i = 0; i < 6; i++) send(img1[i], (i == 5));
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    n_fill = push_fill();
    check("t1_words", 32'(words_loaded), 32'd6);
    check("t1_ready_drop", 32'(ld_ready), 32'd0);
    reload = 1'b1;
    expect_release(n_fill);
    check("t1_words_frozen", 32'(words_loaded), 32'd6);

    // Reload from RUN, then a two-word image.
    do_reload();
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b1);
    ld_valid = 1'b0;
    n_fill = push_fill();
    check("t4_words", 32'(words_loaded), 32'd2);
    expect_release(n_fill);

    // Three-word image with valid toggling 1,0,1,0.
    do_reload();
    send(mk_instr(OPC_ADD, 3'd1, 3'd2, 3'd3), 1'b0);
    ld_valid = 1'b0;
    @(negedge CLK); #1;
    send(mk_instr(OPC_SUB, 3'd4, 3'd5, 3'd6), 1'b0);
    ld_valid = 1'b0;
    @(negedge CLK); #1;
    send(mk_instr(OPC_LD, 3'd7, 3'd0, 3'd1), 1'b1);
    ld_valid = 1'b0;
    n_fill = push_fill();
    check("t2_words", 32'(words_loaded), 32'd3);
    expect_release(n_fill);
    check("t2_words_frozen", 32'(words_loaded), 32'd3);

    // Full memory: eight words without ld_last, then a ninth is presented.
    do_reload();
    for (int i = 0; i < DEPTH; i++) send(WORD_W'(16'hA000 + i), 1'b0);
    ld_data  = 16'hDEAD;
    ld_last  = 1'b1;
    ld_valid = 1'b1;
    n_fill = push_fill();
    check("t3_words", 32'(words_loaded), 32'd8);
    check("t3_ninth_not_ready", 32'(ld_ready), 32'd0);
    expect_release(n_fill);
    check("t3_words_frozen", 32'(words_loaded), 32'd8);
    ld_valid = 1'b0;
    ld_last  = 1'b0;

    // Asynchronous RESET after three accepts, then a fresh load from address 0.
    do_reload();
    for (int i = 0; i < 3; i++) send(WORD_W'(16'h5550 + i), 1'b0);
    ld_valid = 1'b0;
    check("t5_words_before", 32'(words_loaded), 32'd3);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_values("async_reset");
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    next_addr = 0;
    #1;
    check("t5_ready_gap", 32'(ld_ready), 32'd0);
    send(16'h7777, 1'b0);
    send(16'h8888, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    n_fill = push_fill();
    check("t5_words", 32'(words_loaded), 32'd2);
    expect_release(n_fill);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Streams a program image into the processor's instruction memory over a valid/ready channel.
- Holds the processor in reset while it loads, then releases it, replacing hand-written memory pokes for program bring-up.
- Sits between a host/bench source and the instruction-memory write port; drives the processor reset.
- Parametrised in word width, memory depth and release delay; supports reload without a global reset.

Parameters:
WORD_W, 16, instruction word width in bits
DEPTH, 8, instruction memory depth in words (power of two, >= 2)
AW, $clog2(DEPTH), address width (derived, not overridden)
HOLD_CYC, 2, cycles cpu_reset stays high after the last write before release (>= 1)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
ld_valid  in  1  source presents a word
ld_data  in  WORD_W  instruction word
ld_last  in  1  marks the final word of the image
ld_ready  out  1  loader accepts a word this cycle
reload  in  1  single-cycle pulse; restarts loading while in RUN
mem_we  out  1  instruction-memory write enable
mem_addr  out  AW  write address
mem_wdata  out  WORD_W  write data
cpu_reset  out  1  reset to processor, active-high
done  out  1  image loaded, processor running
words_loaded  out  AW+1  count of words written in the current load

Behaviour:
- RESET is asserted asynchronously and forces all of the following:
  - state=LOAD, cpu_reset=1, ld_ready=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, done=0, words_loaded=0, hold counter=0.
- States: LOAD, FILL (feature only), HOLD, RUN. There are no other states.
- LOAD:
  - ld_ready=1 every cycle except the first cycle after RESET deasserts (the registered ready rises one cycle after reset release).
  - A word is accepted on a rising edge when ld_valid && ld_ready.
  - Accept registers mem_we=1, mem_addr=next address, mem_wdata=ld_data. The write is visible one cycle after the accept; latency is 1.
  - The address increments per accept; words_loaded increments per accept.
  - A cycle without an accept registers mem_we=0.
- Load termination: accept with ld_last=1, or accept at address DEPTH-1 (memory full, ld_last ignored).
  - Next state is FILL if ZERO_FILL_EN is defined and the memory is not full; otherwise HOLD.
  - ld_ready drops to 0 in the cycle after the terminating accept.
- No wrap-around: an image never writes past address DEPTH-1. Words presented after full are not accepted (ld_ready=0).
- HOLD:
  - cpu_reset=1, mem_we=0 after the final write.
  - Counts HOLD_CYC cycles, then goes to RUN.
- RUN:
  - cpu_reset=0, done=1, ld_ready=0.
  - words_loaded and the memory contents are frozen.
- reload pulse in RUN:
  - Next cycle: state=LOAD, cpu_reset=1, done=0, address=0, words_loaded=0.
  - ld_ready=1 in the following cycle.
- reload in any other state is ignored.
- ld_valid while not ready is held by the source (standard valid/ready); the loader never drops an accepted word.
- RESET mid-load or mid-HOLD: immediate return to LOAD at address 0. Partially written memory is not cleared.

Optional Feature:
- Macro ZERO_FILL_EN.
- Defined:
  - After a terminating accept that does not fill memory, FILL writes 0 (NOP) to each remaining address, one per cycle, up to DEPTH-1.
  - words_loaded does not count fill writes.
  - HOLD starts after the last fill write.
- Undefined: FILL state and its logic are absent; unused addresses keep their prior contents.

Decomposition:
- Shared package holds:
  - state enum {LOAD, FILL, HOLD, RUN}.
  - NOP_WORD constant (all zeros).
  - Opcode field constants (7-bit opcode, 3-bit DR/SA/SB fields) for bench program construction.
- One sub-module is natural: boot_hold_counter. It is a parametrised down-counter of width $clog2(HOLD_CYC+1) with load/zero outputs, used in HOLD.

Test Plan:
1. Six-word load with ld_last on word 6, ld_valid held high (data 16'h9819, 16'h9826, 16'h401C, 16'h20D8, 16'h8491, 16'h04D3).
   - mem_we pulses at addresses 0..5 in consecutive cycles with exact data.
   - words_loaded=6.
   - cpu_reset falls exactly HOLD_CYC cycles after the address-5 write; done=1.
2. Backpressure/gaps: ld_valid toggles 1,0,1,0 on a 3-word image.
   - Writes occur only on accept cycles.
   - Addresses 0,1,2 have no gaps in the address sequence.
   - No duplicate writes.
3. Full memory: DEPTH=8, eight words with ld_last=0, then a ninth word presented.
   - Load terminates at address 7; the ninth word is never accepted (ld_ready=0).
   - words_loaded=8.
4. Reload: in RUN, pulse reload, then load 2 words.
   - cpu_reset=1 next cycle, done=0.
   - Writes go to addresses 0 and 1; words_loaded=2; release follows after HOLD_CYC.
5. RESET asserted mid-load after 3 accepts, async between clock edges.
   - Outputs take their reset values immediately.
   - A subsequent load restarts at address 0.
6. ZERO_FILL_EN defined, 3-word image, DEPTH=8.
   - Addresses 3..7 are written with 16'h0000 in 5 consecutive cycles.
   - words_loaded=3; release follows after the fill and HOLD_CYC.
